// File: rtl/chaos_fifo_pkg.sv
// Field layout and FSM encoding shared by both sides of the 140-bit
// clock-crossing FIFO (write-side packer and read-side unpacker).
package chaos_fifo_pkg;

   localparam int DATA_W   = 140;
   localparam int BEAT_W   = 16;
   localparam int BEATS    = 8;
   localparam int CHAN_W   = 8;
   localparam int CNT_W    = 4;
   localparam int CNT_LSB  = 136;
   localparam int CHAN_LSB = 128;
   localparam int IDX_W    = $clog2(BEATS);

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

   // A word is well-formed when it carries between 1 and BEATS beats.
   function automatic logic cnt_ok(input logic [CNT_W-1:0] cnt);
      return (cnt != '0) && (cnt <= CNT_W'(BEATS));
   endfunction

endpackage

// File: rtl/fifo_beat_unpacker.sv
// Pops packed FIFO words and streams them out as 16-bit beats with channel
// id and last-beat sideband; malformed beat counts are dropped and counted.
module fifo_beat_unpacker
   import chaos_fifo_pkg::*;
#(
   parameter int DROP_W = 16
) (
   input  logic              clk_out,
   input  logic              rst_n,
   input  logic              fifo_empty,
   output logic              fifo_r_enable,
   input  logic [DATA_W-1:0] data_from_fifo,
   output logic [BEAT_W-1:0] dout_data,
   output logic [CHAN_W-1:0] dout_chan,
   output logic              dout_last,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DROP_W-1:0] drop_cnt
);

   state_t                         state, state_next;
   logic [DATA_W-1:0]              hold;
   logic [IDX_W-1:0]               idx;
   logic [BEATS-1:0][BEAT_W-1:0]   payload;
   logic [CNT_W-1:0]               hold_cnt;
   logic                           load_ok;
   logic                           last_beat;
   logic                           accept;

   assign payload   = hold[BEATS*BEAT_W-1:0];
   assign hold_cnt  = hold[CNT_LSB +: CNT_W];
   assign load_ok   = cnt_ok(data_from_fifo[CNT_LSB +: CNT_W]);
   assign last_beat = (CNT_W'(idx) == hold_cnt - CNT_W'(1));
   assign accept    = dout_valid && dout_ready;

   // State register
   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!fifo_empty) state_next = FETCH;
         FETCH:   state_next = LOAD;
         LOAD:    state_next = load_ok ? SEND : IDLE;
         SEND:    if (accept && last_beat) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: valid is a pure state decode so it never looks at ready
   always_comb begin
      dout_valid = (state == SEND);
      dout_last  = (state == SEND) && last_beat;
      dout_data  = payload[idx];
      dout_chan  = hold[CHAN_LSB +: CHAN_W];
   end

   // Pop strobe is registered off the next state, so it is high exactly in FETCH
   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) fifo_r_enable <= 1'b0;
      else        fifo_r_enable <= (state_next == FETCH);
   end

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         hold <= '0;
         idx  <= '0;
      end else if (state == LOAD) begin
         hold <= data_from_fifo;
         idx  <= '0;
      end else if (state == SEND && accept) begin
         idx  <= idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n)
         drop_cnt <= '0;
      else if (state == LOAD && !load_ok && drop_cnt != '1)
         drop_cnt <= drop_cnt + DROP_W'(1);
   end

endmodule

// File: tb/tb_fifo_beat_unpacker.sv
// Directed bench for fifo_beat_unpacker; the bench plays the FIFO read side.
module tb_fifo_beat_unpacker;
   import chaos_fifo_pkg::*;

   logic              clk_out = 1'b0;
   logic              rst_n;
   logic              fifo_empty;
   logic              fifo_r_enable;
   logic [DATA_W-1:0] data_from_fifo;
   logic [BEAT_W-1:0] dout_data;
   logic [CHAN_W-1:0] dout_chan;
   logic              dout_last;
   logic              dout_valid;
   logic              dout_ready;
   logic [15:0]       drop_cnt;

   // narrow-counter instance so counter saturation is reachable quickly
   logic              s_empty;
   logic              s_ren;
   logic [DATA_W-1:0] s_data;
   logic [BEAT_W-1:0] s_dd;
   logic [CHAN_W-1:0] s_dc;
   logic              s_dl;
   logic              s_dv;
   logic              s_ready;
   logic [3:0]        s_drop;

   int checks = 0;
   int errors = 0;
   int pops   = 0;

   always #5 clk_out = ~clk_out;

   always @(posedge clk_out) if (fifo_r_enable) pops <= pops + 1;

   fifo_beat_unpacker #(.DROP_W(16)) dut (
      .clk_out(clk_out), .rst_n(rst_n), .fifo_empty(fifo_empty),
      .fifo_r_enable(fifo_r_enable), .data_from_fifo(data_from_fifo),
      .dout_data(dout_data), .dout_chan(dout_chan), .dout_last(dout_last),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .drop_cnt(drop_cnt)
   );

   fifo_beat_unpacker #(.DROP_W(4)) u_sat (
      .clk_out(clk_out), .rst_n(rst_n), .fifo_empty(s_empty),
      .fifo_r_enable(s_ren), .data_from_fifo(s_data),
      .dout_data(s_dd), .dout_chan(s_dc), .dout_last(s_dl),
      .dout_valid(s_dv), .dout_ready(s_ready), .drop_cnt(s_drop)
   );

   function automatic logic [DATA_W-1:0] mk(input logic [3:0] c, input logic [7:0] ch,
                                            input logic [7:0][15:0] p);
      return {c, ch, p};
   endfunction

   // Offer one word; returns at the negedge where the pop strobe is seen.
   task automatic serve(input logic [DATA_W-1:0] w, input logic more, output int n);
      n = 0;
      fifo_empty = 1'b0;
      while (!fifo_r_enable && n < 20) begin
         @(negedge clk_out);
         n++;
      end
      data_from_fifo = w;
      fifo_empty     = !more;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fifo_empty = 1'b1;
      data_from_fifo = '0;
      dout_ready = 1'b0;
      s_empty = 1'b1;
      s_data = '0;
      s_ready = 1'b1;
      repeat (2) @(negedge clk_out);
      checks++;
      if (fifo_r_enable !== 1'b0 || dout_valid !== 1'b0 || dout_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl ren=%b valid=%b last=%b expected 0/0/0",
                  fifo_r_enable, dout_valid, dout_last);
      end
      checks++;
      if (dout_data !== 16'h0 || dout_chan !== 8'h0 || drop_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_data data=%h chan=%h drop=%h expected 0/0/0",
                  dout_data, dout_chan, drop_cnt);
      end
      rst_n = 1'b1;
      @(negedge clk_out);
   endtask

   task automatic test_single();
      logic [7:0][15:0] p;
      int n, p0;
      p = '0;
      p[0] = 16'h1111; p[1] = 16'h2222; p[2] = 16'h3333;
      dout_ready = 1'b1;
      p0 = pops;
      serve(mk(4'd3, 8'h5A, p), 1'b0, n);
      checks++;
      if (n >= 20) begin errors++; $display("FAIL single_pop timeout n=%0d expected <20", n); end
      repeat (2) @(negedge clk_out);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dout_valid !== 1'b1 || dout_data !== p[k] || dout_chan !== 8'h5A ||
             dout_last !== (k == 2)) begin
            errors++;
            $display("FAIL single_beat%0d valid=%b data=%h chan=%h last=%b expected 1/%h/5a/%b",
                     k, dout_valid, dout_data, dout_chan, dout_last, p[k], (k == 2));
         end
         @(negedge clk_out);
      end
      checks++;
      if (dout_valid !== 1'b0 || pops - p0 !== 1) begin
         errors++;
         $display("FAIL single_end valid=%b pops=%0d expected 0/1", dout_valid, pops - p0);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0][15:0] p;
      int n, p0, e;
      for (int k = 0; k < 8; k++) p[k] = 16'hB000 + 16'(k);
      e  = 0;
      p0 = pops;
      serve(mk(4'd8, 8'hC3, p), 1'b1, n);
      checks++;
      if (n >= 20) begin errors++; $display("FAIL bp_pop timeout n=%0d expected <20", n); end
      for (int c = 0; c < 60 && e < 8; c++) begin
         @(negedge clk_out);
         if (dout_valid) begin
            checks++;
            if (dout_data !== p[e] || dout_chan !== 8'hC3 || dout_last !== (e == 7)) begin
               errors++;
               $display("FAIL bp_beat%0d data=%h chan=%h last=%b expected %h/c3/%b",
                        e, dout_data, dout_chan, dout_last, p[e], (e == 7));
            end
         end
         dout_ready = (c % 3 == 0);
         if (dout_valid && dout_ready) e++;
      end
      @(negedge clk_out);
      fifo_empty = 1'b1;
      dout_ready = 1'b1;
      checks++;
      if (e !== 8 || pops - p0 !== 1) begin
         errors++;
         $display("FAIL bp_done beats=%0d pops=%0d expected 8/1", e, pops - p0);
      end
      repeat (2) @(negedge clk_out);
   endtask

   task automatic test_drop();
      logic [7:0][15:0] p;
      logic [3:0] c;
      logic [7:0] ch;
      int n, nb;
      dout_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         p = '0;
         case (i)
            0:       begin c = 4'd0; p[0] = 16'hDEAD; end
            1:       begin c = 4'd1; p[0] = 16'hBEEF; end
            2:       begin c = 4'd9; p[0] = 16'hF00D; end
            default: begin c = 4'd1; p[0] = 16'hCAFE; end
         endcase
         ch = 8'h11 * 8'(i + 1);
         nb = 0;
         serve(mk(c, ch, p), 1'b0, n);
         checks++;
         if (n >= 20) begin errors++; $display("FAIL drop_pop%0d timeout n=%0d", i, n); end
         repeat (5) begin
            @(negedge clk_out);
            if (dout_valid) begin
               nb++;
               checks++;
               if (dout_data !== p[0] || dout_chan !== ch || dout_last !== 1'b1) begin
                  errors++;
                  $display("FAIL drop_beat%0d data=%h chan=%h last=%b expected %h/%h/1",
                           i, dout_data, dout_chan, dout_last, p[0], ch);
               end
            end
         end
         checks++;
         if (nb !== i % 2 || drop_cnt !== 16'(i / 2 + 1)) begin
            errors++;
            $display("FAIL drop_word%0d beats=%0d drop=%0d expected %0d/%0d",
                     i, nb, drop_cnt, i % 2, i / 2 + 1);
         end
      end
   endtask

   task automatic test_idle_empty();
      int p0;
      fifo_empty = 1'b1;
      p0 = pops;
      repeat (20) begin
         @(negedge clk_out);
         checks++;
         if (fifo_r_enable !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_empty ren=%b valid=%b expected 0/0", fifo_r_enable, dout_valid);
         end
      end
      checks++;
      if (pops !== p0) begin errors++; $display("FAIL idle_pops got=%0d expected 0", pops - p0); end
   endtask

   task automatic test_reset_mid();
      logic [7:0][15:0] p;
      int n;
      p = '0;
      for (int k = 0; k < 5; k++) p[k] = 16'hD000 + 16'(k);
      dout_ready = 1'b1;
      serve(mk(4'd5, 8'h77, p), 1'b0, n);
      repeat (4) @(negedge clk_out);
      checks++;
      if (dout_valid !== 1'b1 || dout_data !== p[2]) begin
         errors++;
         $display("FAIL rst_pre valid=%b data=%h expected 1/%h", dout_valid, dout_data, p[2]);
      end
      dout_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dout_valid !== 1'b0 || fifo_r_enable !== 1'b0 || drop_cnt !== 16'h0 ||
          dout_data !== 16'h0 || dout_last !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid valid=%b ren=%b drop=%h data=%h last=%b expected all 0",
                  dout_valid, fifo_r_enable, drop_cnt, dout_data, dout_last);
      end
      @(negedge clk_out);
      rst_n = 1'b1;
      dout_ready = 1'b1;
      p = '0;
      p[0] = 16'hE0E0; p[1] = 16'hE1E1;
      serve(mk(4'd2, 8'h99, p), 1'b0, n);
      checks++;
      if (n < 1 || n > 2) begin errors++; $display("FAIL rst_repop cycles=%0d expected 1..2", n); end
      repeat (2) @(negedge clk_out);
      checks++;
      if (dout_valid !== 1'b1 || dout_data !== 16'hE0E0 || dout_chan !== 8'h99 || dout_last !== 1'b0) begin
         errors++;
         $display("FAIL rst_beat0 valid=%b data=%h chan=%h last=%b expected 1/e0e0/99/0",
                  dout_valid, dout_data, dout_chan, dout_last);
      end
      @(negedge clk_out);
      checks++;
      if (dout_valid !== 1'b1 || dout_data !== 16'hE1E1 || dout_last !== 1'b1) begin
         errors++;
         $display("FAIL rst_beat1 valid=%b data=%h last=%b expected 1/e1e1/1",
                  dout_valid, dout_data, dout_last);
      end
      @(negedge clk_out);
   endtask

   task automatic test_saturate();
      int bad;
      bad = 0;
      s_data  = {4'd0, 8'hEE, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF};
      s_empty = 1'b0;
      repeat (80) begin
         @(negedge clk_out);
         if (s_dv) bad++;
      end
      s_empty = 1'b1;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL sat_valid got=%0d expected 0", bad); end
      checks++;
      if (s_drop !== 4'hF) begin errors++; $display("FAIL sat_drop got=%h expected f", s_drop); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_drop();
      test_idle_empty();
      test_reset_mid();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
